// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The LOADER_CHECKSUM_EN macro is honoured by the loader top, not here.
package loader_pkg;

    localparam int          NUM_LANES         = 4;
    localparam int          LANE_W            = $clog2(NUM_LANES);
    localparam int unsigned DEFAULT_MAX_WORDS = 16384;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Host byte stream, instruction-memory write port and status flags.
// master = host/testbench side, slave = loader side.
interface inst_mem_loader_if;

    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold
    );

endinterface

// File: rtl/inst_mem_loader_byte_packer.sv
// Assembles NUM_LANES bytes little-endian into one word; o_word_valid pulses
// combinationally alongside the last byte so the caller can register the word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [LANE_W-1:0]          r_lane;
    logic [8*(NUM_LANES-1)-1:0] r_buf;

    assign o_word_valid = i_byte_valid && (r_lane == LANE_W'(NUM_LANES - 1));
    assign o_word       = {i_byte, r_buf};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane <= '0;
            r_buf  <= '0;
        end else if (i_clr) begin
            r_lane <= '0;
            r_buf  <= '0;
        end else if (i_byte_valid) begin
            r_lane <= r_lane + LANE_W'(1);
            for (int k = 0; k < NUM_LANES - 1; k++)
                if (r_lane == LANE_W'(k)) r_buf[8*k +: 8] <= i_byte;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a length-prefixed image from a byte host into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module inst_mem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    inst_mem_loader_if.slave  bus
);

    state_e      r_state;
    logic [1:0]  r_len_cnt;
    logic [31:0] r_len;
    logic [31:0] r_word_idx;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic        w_in_ready;
    logic        w_accept;
    logic        w_start_ok;
    logic        w_pk_valid;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic [31:0] w_len_n;
    logic [31:0] w_addr;
    state_e      w_after_data;

    assign w_in_ready = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_start_ok = bus.start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_pk_valid = w_accept && (r_state == S_DATA);
    assign w_len_n    = {bus.in_data, r_len[23:0]};
    assign w_addr     = (BASE_ADDR + (r_word_idx << 2)) & 32'hFFFF_FFFC;
`ifdef LOADER_CHECKSUM_EN
    assign w_after_data = S_CSUM;
`else
    assign w_after_data = S_DONE;
`endif

    byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (w_start_ok),
        .i_byte_valid (w_pk_valid),
        .i_byte       (bus.in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_len_cnt   <= '0;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (w_start_ok) begin
                        r_state    <= S_LEN;
                        r_len_cnt  <= '0;
                        r_len      <= '0;
                        r_word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum      <= '0;
`endif
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        r_len_cnt <= r_len_cnt + 2'd1;
                        for (int k = 0; k < NUM_LANES - 1; k++)
                            if (r_len_cnt == 2'(k)) r_len[8*k +: 8] <= bus.in_data;
                        if (r_len_cnt == 2'd3) begin
                            r_len <= w_len_n;
                            if (w_len_n > MAX_WORDS)   r_state <= S_ERR;
                            else if (w_len_n == '0)    r_state <= w_after_data;
                            else                       r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                    if (w_accept) r_sum <= r_sum + bus.in_data;
`endif
                    if (w_word_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_word;
                        r_word_idx  <= r_word_idx + 32'd1;
                        if (r_word_idx + 32'd1 == r_len) r_state <= w_after_data;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    // The trailing byte is the two's complement of the data sum.
                    if (w_accept)
                        r_state <= (8'(r_sum + bus.in_data) == 8'h00) ? S_DONE : S_ERR;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = w_in_ready;
    assign bus.done      = (r_state == S_DONE);
    assign bus.error     = (r_state == S_ERR);
    assign bus.cpu_hold  = (r_state != S_DONE);

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench: two loaders (base 0 and base 0x100) share one random
// byte stream; expected writes are queued at issue and popped by a monitor.
module tb_inst_mem_loader;
    import loader_pkg::*;

    localparam logic [31:0] BASE_B = 32'h0000_0100;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    int          n_checks = 0;
    int          n_errors = 0;
    wr_t         qa[$];
    wr_t         qb[$];
    logic [31:0] img[$];

    always #5 clk = ~clk;

    inst_mem_loader_if ifa();
    inst_mem_loader_if ifb();

    assign ifa.start = start;  assign ifa.in_valid = in_valid;  assign ifa.in_data = in_data;
    assign ifb.start = start;  assign ifb.in_valid = in_valid;  assign ifb.in_data = in_data;

    inst_mem_loader #(.BASE_ADDR(32'h0)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
    inst_mem_loader #(.BASE_ADDR(BASE_B)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        wr_t e;
        if (rst_n && ifa.mem_we) begin
            if (qa.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL dut_a unexpected write: got addr %h data %h required none", ifa.mem_addr, ifa.mem_wdata);
            end else begin
                e = qa.pop_front();
                check("dut_a write addr", ifa.mem_addr, e.addr);
                check("dut_a write data", ifa.mem_wdata, e.data);
            end
        end
        if (rst_n && ifb.mem_we) begin
            if (qb.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL dut_b unexpected write: got addr %h data %h required none", ifb.mem_addr, ifb.mem_wdata);
            end else begin
                e = qb.pop_front();
                check("dut_b write addr", ifb.mem_addr, e.addr);
                check("dut_b write data", ifb.mem_wdata, e.data);
            end
        end
    end

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err, input bit exp_busy);
        check({tag, " a done"},     ifa.done,     exp_done);
        check({tag, " a error"},    ifa.error,    exp_err);
        check({tag, " a cpu_hold"}, ifa.cpu_hold, !exp_done);
        check({tag, " a busy"},     ifa.busy,     exp_busy);
        check({tag, " a in_ready"}, ifa.in_ready, exp_busy);
        check({tag, " b done"},     ifb.done,     exp_done);
        check({tag, " b error"},    ifb.error,    exp_err);
        check({tag, " b cpu_hold"}, ifb.cpu_hold, !exp_done);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " a in_ready"}, ifa.in_ready, 0);
        check({tag, " a mem_we"},   ifa.mem_we,   0);
        check({tag, " a mem_addr"}, ifa.mem_addr, 0);
        check({tag, " a wdata"},    ifa.mem_wdata, 0);
        check({tag, " b mem_addr"}, ifb.mem_addr, 0);
        check({tag, " b wdata"},    ifb.mem_wdata, 0);
        check_status(tag, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps)
            while ($urandom_range(0, 2) == 0) begin
                in_data = 8'($urandom);
                @(negedge clk);
            end
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!ifa.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ifa.in_ready) begin
            n_checks++; n_errors++;
            $display("FAIL send_byte in_ready: got 0 required 1");
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] n, input bit gaps,
                        input bit bad_cs, input bit mid_start);
        logic [7:0] sum, cs, tot;
        bit         exp_err;
        wr_t        e;
        sum = 8'h00;
        exp_err = 1'b0;
        pulse_start();
        for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], gaps);
        if (n > DEFAULT_MAX_WORDS) exp_err = 1'b1;
        else begin
            for (int i = 0; i < int'(n); i++) begin
                e.data = img[i];
                e.addr = 32'(i) * 4;           qa.push_back(e);
                e.addr = BASE_B + 32'(i) * 4;  qb.push_back(e);
                for (int k = 0; k < 4; k++) begin
                    sum = sum + img[i][8*k +: 8];
                    send_byte(img[i][8*k +: 8], gaps);
                    if (mid_start && i == 0 && k == 1) pulse_start();
                end
            end
            if (CSUM_EN) begin
                cs = bad_cs ? 8'h00 : 8'h00 - sum;
                send_byte(cs, gaps);
                tot = sum + cs;
                exp_err = (tot != 8'h00);
            end
        end
        @(negedge clk);
        #1;
        check_status(tag, !exp_err, exp_err, 1'b0);
        check({tag, " a writes drained"}, qa.size(), 0);
        check({tag, " b writes drained"}, qb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        img = '{32'h0000_0013};
        load("single word", 32'd1, 1'b0, 1'b0, 1'b0);

        img = '{32'h0050_0093, 32'h00A0_0113};
        load("two words", 32'd2, 1'b0, 1'b0, 1'b0);

        load("len too big", 32'd16385, 1'b0, 1'b0, 1'b0);

        if (CSUM_EN) begin
            img = '{32'h0000_0013};
            load("bad checksum", 32'd1, 1'b0, 1'b1, 1'b0);
        end else begin
            load("len max+huge", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        end
        pulse_start();
        #1;
        check_status("restart after err", 1'b0, 1'b0, 1'b1);

        // Abort mid-word: reset asynchronously between clock edges.
        for (int b = 0; b < 4; b++) send_byte((b == 0) ? 8'h01 : 8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("after reset");

        img.delete();
        for (int i = 0; i < 2; i++) img.push_back($urandom);
        load("post reset", 32'd2, 1'b0, 1'b0, 1'b0);

        img.delete();
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        load("gappy + start", 32'd3, 1'b1, 1'b0, 1'b1);

        load("zero length", 32'd0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            img.delete();
            for (int i = 0; i < 5; i++) img.push_back($urandom);
            load($sformatf("random %0d", t), 32'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                 CSUM_EN && ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
